pulse_stretch: RTL and testbench

Output-side counterpart to the input debouncer. It converts single-cycle event strobes from internal logic into clean, glitch-free output pulses that have a guaranteed minimum high time and a guaranteed minimum low time. The block is used for LEDs, external strobes and relay drivers. Requests that arrive while a pulse is in progress are queued in a saturating counter and replayed back-to-back.

---
 rtl/pulse_stretch_if.sv | 26 ++
 rtl/pulse_stretch.sv | 142 ++++++++++++++
 tb/tb_pulse_stretch.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pulse_stretch_if.sv
// pulse_stretch_if: request/status bundle for the pulse stretcher.
//   i_Trigger  - request strobe into the stretcher
//   o_Out      - stretched output pulse
//   o_Busy     - stretcher is in a pulse or its trailing gap
//   o_Pending  - queued requests that have not started yet
//   o_Overflow - sticky flag: a request was dropped
// Modports: master = request source, slave = stretcher.
interface pulse_stretch_if #(
  parameter int p_PEND_W = 3
) ();
  logic                i_Trigger;
  logic                o_Out;
  logic                o_Busy;
  logic [p_PEND_W-1:0] o_Pending;
  logic                o_Overflow;

  modport master (
    output i_Trigger,
    input  o_Out, o_Busy, o_Pending, o_Overflow
  );

  modport slave (
    input  i_Trigger,
    output o_Out, o_Busy, o_Pending, o_Overflow
  );
endinterface

// File: rtl/pulse_stretch.sv
// pulse_stretch: turns single-cycle request strobes into output pulses with a
// guaranteed high time (p_ON_CYCLES) and a guaranteed low time afterwards
// (p_OFF_CYCLES). Requests arriving during a pulse are queued in a saturating
// counter and replayed back-to-back; a dropped request sets a sticky flag.
// Ports:
//   i_CLK - clock, rising edge
//   i_RST - synchronous active-high reset
//   bus   - pulse_stretch_if.slave (trigger in; out/busy/pending/overflow out)
module pulse_stretch #(
  parameter int p_ON_CYCLES  = 4,
  parameter int p_OFF_CYCLES = 4,
  parameter int p_PEND_W     = 3
) (
  input  logic            i_CLK,
  input  logic            i_RST,
  pulse_stretch_if.slave  bus
);

  localparam int MAX_LIM = (p_ON_CYCLES > p_OFF_CYCLES) ? p_ON_CYCLES : p_OFF_CYCLES;
  localparam int CNT_W   = (MAX_LIM > 1) ? $clog2(MAX_LIM) : 1;

  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    ON_LAST  = CNT_W'(p_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]    OFF_LAST = CNT_W'(p_OFF_CYCLES - 1);
  localparam logic [p_PEND_W-1:0] PEND_ONE = p_PEND_W'(1);
  localparam logic [p_PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  // NOTE: declaration initialisers equal the reset values so power-up and
  // post-reset behaviour are identical on targets that honour them.
  state_e              state_q = S_IDLE;
  logic [CNT_W-1:0]    cnt_q   = '0;
  logic [p_PEND_W-1:0] pend_q  = '0;
  logic                ovf_q   = 1'b0;
  logic                out_q   = 1'b0;
  logic                busy_q  = 1'b0;

  state_e              state_d;
  logic [CNT_W-1:0]    cnt_d;
  logic [p_PEND_W-1:0] pend_d;
  logic                ovf_d;
  logic                out_d;
  logic                busy_d;

  logic last_on;
  logic last_gap;
  logic start;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;

    last_on  = (state_q == S_ON)  && (cnt_q == ON_LAST);
    last_gap = (state_q == S_GAP) && (cnt_q == OFF_LAST);
    start    = ((state_q == S_IDLE) || last_gap) &&
               (bus.i_Trigger || (pend_q != '0));

    // Queue bookkeeping. With an empty queue a starting trigger is consumed
    // directly; with a non-empty queue a start pops one entry and a
    // simultaneous trigger pushes one, which cancels out.
    if (start) begin
      if ((pend_q != '0) && !bus.i_Trigger) begin
        pend_d = pend_q - PEND_ONE;
      end
    end else if (bus.i_Trigger) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_ONE;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ON;
          cnt_d   = '0;
        end
      end
      S_ON: begin
        if (last_on) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_GAP: begin
        if (last_gap) begin
          state_d = start ? S_ON : S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs come from the next state so they are flop-driven and carry no
    // combinational path from the trigger input.
    out_d  = (state_d == S_ON);
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values of the others.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_Out      = out_q;
  assign bus.o_Busy     = busy_q;
  assign bus.o_Pending  = pend_q;
  assign bus.o_Overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch: scoreboard bench for pulse_stretch. Two configurations run
// side by side (defaults 4/4/3 and the minimum 1/1 with a 2-bit queue). A
// driver applies directed then random triggers/resets, advances a timeline
// model (pulse start time + queued-request count) and pushes the expected
// outputs; a monitor pops and compares after every clock edge.
module tb_pulse_stretch;

  localparam int NCYC = 2200;
  localparam int DENS [4] = '{5, 30, 70, 100};

  typedef struct {
    bit out;
    bit busy;
    int pend;
    bit ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit [1:0] mon_done = 2'b00;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  function automatic bit dir_trig(input int c);
    return (c == 10) || (c >= 30 && c <= 33) || (c >= 60 && c <= 71) ||
           (c == 120) || (c == 125) || (c == 140);
  endfunction

  function automatic bit dir_rst(input int c);
    return (c < 3) || (c == 122) || (c == 140);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int ON   = (g == 0) ? 4 : 1;
    localparam int OFF  = (g == 0) ? 4 : 1;
    localparam int PW   = (g == 0) ? 3 : 2;
    localparam int PMAX = (1 << PW) - 1;

    logic rst;
    exp_t q [$];

    pulse_stretch_if #(.p_PEND_W(PW)) ifc ();

    pulse_stretch #(
      .p_ON_CYCLES (ON),
      .p_OFF_CYCLES(OFF),
      .p_PEND_W    (PW)
    ) dut (
      .i_CLK(clk),
      .i_RST(rst),
      .bus  (ifc.slave)
    );

    // Driver + reference model. The model only remembers when the current
    // pulse started and how many requests wait; a new pulse may begin on any
    // edge at or after start+ON+OFF (the last gap cycle or any idle cycle).
    initial begin
      bit have = 1'b0;
      int last_start = 0;
      int pend = 0;
      bit ovf = 1'b0;
      bit trig;
      bit r;
      bit free;
      int d;
      exp_t e;
      rst = 1'b1;
      ifc.i_Trigger = 1'b0;
      for (int c = 0; c < NCYC; c++) begin
        @(negedge clk);
        if (c < 150) begin
          trig = dir_trig(c);
          r    = dir_rst(c);
        end else begin
          trig = ($urandom_range(0, 99) < DENS[(c / 200) % 4]);
          r    = ($urandom_range(0, 599) == 0);
        end
        ifc.i_Trigger = trig;
        rst = r;

        if (r) begin
          have = 1'b0;
          pend = 0;
          ovf  = 1'b0;
        end else begin
          free = !have || (c >= last_start + ON + OFF);
          if (free && (trig || pend > 0)) begin
            if (pend > 0 && !trig) pend--;
            have = 1'b1;
            last_start = c;
          end else if (trig) begin
            if (pend == PMAX) ovf = 1'b1;
            else pend++;
          end
        end

        d = c + 1 - last_start;
        e.out  = have && (d >= 1) && (d <= ON);
        e.busy = have && (d >= 1) && (d <= ON + OFF);
        e.pend = pend;
        e.ovf  = ovf;
        q.push_back(e);
      end
      @(negedge clk);
      ifc.i_Trigger = 1'b0;
      rst = 1'b0;
    end

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
      exp_t e;
      int k;
      k = 0;
      for (int n = 0; n < NCYC + 4; n++) begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
          e = q.pop_front();
          check($sformatf("cfg%0d cyc%0d out", g, k), 32'(ifc.o_Out), 32'(e.out));
          check($sformatf("cfg%0d cyc%0d busy", g, k), 32'(ifc.o_Busy), 32'(e.busy));
          check($sformatf("cfg%0d cyc%0d pending", g, k), 32'(ifc.o_Pending), 32'(e.pend));
          check($sformatf("cfg%0d cyc%0d overflow", g, k), 32'(ifc.o_Overflow), 32'(e.ovf));
          k++;
        end
      end
      mon_done[g] = 1'b1;
    end
  end

  initial begin
    wait (mon_done == 2'b11);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
